// File: rtl/pipeline_sequencer_if.sv
// Hazard/redirect request and stage-control bundle for pipeline_sequencer.
// slave = the sequencer, master = the pipeline that raises requests and consumes enables.
interface pipeline_sequencer_if;
  logic        exeRedirect;
  logic [31:0] exeTarget;
  logic        decRedirect;
  logic [31:0] decTarget;
  logic        loadUse;
  logic        memBusy;
  logic        enIF;
  logic        enDEC;
  logic        enEXE;
  logic        flushDEC;
  logic        flushEXE;
  logic [1:0]  pcSel;
  logic [31:0] pcNext;
  logic        stallErr;
  logic [31:0] stallCount;
  logic [31:0] flushCount;

  modport master (
    output exeRedirect, exeTarget, decRedirect, decTarget, loadUse, memBusy,
    input  enIF, enDEC, enEXE, flushDEC, flushEXE, pcSel, pcNext,
           stallErr, stallCount, flushCount
  );

  modport slave (
    input  exeRedirect, exeTarget, decRedirect, decTarget, loadUse, memBusy,
    output enIF, enDEC, enEXE, flushDEC, flushEXE, pcSel, pcNext,
           stallErr, stallCount, flushCount
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline hazard/redirect sequencer: stage enables, flushes and PC select.
// Optional PIPE_PERF_COUNTERS_EN adds 32-bit stall/flush performance counters.
module pipeline_sequencer #(
  parameter int unsigned STALL_LIMIT = 256
) (
  input  logic                 Clock,
  input  logic                 Reset,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, SHADOW} state_t;

  state_t      state, state_nx;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [15:0] busy_cnt;
  logic [16:0] busy_inc;
  logic        stall_err;
  logic        exe_take;
  logic [31:0] exe_tgt;

  // A fresh EXE redirect overrides one parked during a memory stall.
  assign exe_take = bus.exeRedirect | pend_valid;
  assign exe_tgt  = bus.exeRedirect ? bus.exeTarget : pend_target;
  assign busy_inc = {1'b0, busy_cnt} + 17'd1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= state_nx;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (bus.memBusy) begin
      if (bus.exeRedirect) begin
        pend_valid  <= 1'b1;
        pend_target <= bus.exeTarget;
      end
    end else begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_cnt  <= '0;
      stall_err <= 1'b0;
    end else if (bus.memBusy) begin
      if (busy_cnt != '1) busy_cnt <= busy_inc[15:0];
      if (32'(busy_inc) >= STALL_LIMIT) stall_err <= 1'b1;
    end else begin
      busy_cnt <= '0;
    end
  end

  always_comb begin
    state_nx     = RUN;
    bus.enIF     = 1'b1;
    bus.enDEC    = 1'b1;
    bus.enEXE    = 1'b1;
    bus.flushDEC = 1'b0;
    bus.flushEXE = 1'b0;
    bus.pcSel    = 2'd0;
    bus.pcNext   = '0;
    if (Reset) begin
      bus.enIF     = 1'b0;
      bus.enDEC    = 1'b0;
      bus.enEXE    = 1'b0;
      bus.flushDEC = 1'b1;
      bus.flushEXE = 1'b1;
    end else if (bus.memBusy) begin
      bus.enIF  = 1'b0;
      bus.enDEC = 1'b0;
      bus.enEXE = 1'b0;
      state_nx  = MEM_WAIT;
    end else if (exe_take) begin
      bus.pcSel    = 2'd2;
      bus.pcNext   = exe_tgt;
      bus.flushDEC = 1'b1;
      bus.flushEXE = 1'b1;
      state_nx     = SHADOW;
    end else if (state != SHADOW && bus.decRedirect) begin
      bus.pcSel    = 2'd1;
      bus.pcNext   = bus.decTarget;
      bus.flushDEC = 1'b1;
    end else if (state != SHADOW && bus.loadUse) begin
      bus.enIF     = 1'b0;
      bus.enDEC    = 1'b0;
      bus.flushEXE = 1'b1;
    end
  end

  assign bus.stallErr = stall_err;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!(bus.enIF & bus.enDEC & bus.enEXE)) stall_q <= stall_q + 32'd1;
      if (bus.flushDEC | bus.flushEXE)         flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.stallCount = stall_q;
  assign bus.flushCount = flush_q;
`else
  assign bus.stallCount = '0;
  assign bus.flushCount = '0;
`endif

endmodule
